// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle shift execution unit for the multi-cycle datapath. Takes an
// operand, an R-type funct and the zero-extended shamt word from decode,
// shifts by at most STEP bits per clock and reports completion with a
// one-cycle done pulse.
//
// Handshake: start is sampled only while idle (busy=0). The cycle after an
// accepted start, busy rises and stays high until done has pulsed for one
// cycle; start is ignored (not queued) while busy. result holds its value
// until the next completion; err qualifies the op and is valid only while
// done=1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   start      request, accepted only in IDLE
//   funct      6'b000000 sll, 6'b000010 srl, 6'b000011 sra; others -> err
//   shamt_ext  zero-extended shift amount; only [SHAMT_W-1:0] is used
//   operand    value to shift (rt)
//   busy       high in SHIFT and DONE
//   done       one-cycle completion pulse
//   err        unsupported funct, valid while done=1
//   result     registered result, updated only on entry to DONE
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [31:0]      shamt_ext,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    localparam logic [31:0] STEP_C = 32'(STEP);

    logic [1:0]         state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    logic [1:0]         op_q;
    logic               sign_q;
    logic               err_q;
    logic [WIDTH-1:0]   result_q;

    logic [SHAMT_W-1:0] shamt_masked;
    logic               supported;
    logic [1:0]         op_dec;
    logic [31:0]        rem_ext;
    logic [SHAMT_W-1:0] d;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   shr;
    logic [WIDTH-1:0]   fill;
    logic [WIDTH-1:0]   shifted;

    // Upper shamt bits are deliberately ignored by the unit.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt_ext[31:SHAMT_W];

    assign shamt_masked = shamt_ext[SHAMT_W-1:0];

    always_comb begin
        supported = 1'b1;
        op_dec    = OP_SLL;
        case (funct)
            F_SLL:   op_dec = OP_SLL;
            F_SRL:   op_dec = OP_SRL;
            F_SRA:   op_dec = OP_SRA;
            default: supported = 1'b0;
        endcase
    end

    // Per-cycle distance d = min(rem, STEP). Compared at 32 bits so a STEP
    // wider than the rem field still behaves (d is then always rem).
    assign rem_ext  = 32'(rem);
    assign d        = (rem_ext > STEP_C) ? STEP_C[SHAMT_W-1:0] : rem;
    assign rem_next = rem - d;

    // Arithmetic fill comes from the sign latched at start, not from the
    // current work MSB, so every step matches one full-width sra.
    assign shr  = work >> d;
    assign fill = ~({WIDTH{1'b1}} >> d);

    always_comb begin
        shifted = work << d;
        case (op_q)
            OP_SRL:  shifted = shr;
            OP_SRA:  shifted = sign_q ? (shr | fill) : shr;
            default: shifted = work << d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            rem      <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= operand;
                        rem    <= shamt_masked;
                        op_q   <= op_dec;
                        sign_q <= operand[WIDTH-1];
                        if (!supported) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            state    <= DONE;
                        end else if (shamt_masked == '0) begin
                            result_q <= operand;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        result_q <= shifted;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == SHIFT) || (state == DONE);
    assign done      = (state == DONE);
    assign err       = err_q;
    assign result    = result_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Directed-vector bench for seq_shift_unit (WIDTH=32, SHAMT_W=5, STEP=4).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so "cycle N+k" below is the k-th falling edge after the rising edge
// that accepted start. Expected results are hand-computed and queued in
// exp_q when an op is issued, then popped when done is observed.
// ---------------------------------------------------------------------------
module tb_seq_shift_unit;

  localparam int WIDTH = 32;
  localparam int MAX_CYCLES = 40;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_BAD = 6'b100000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [5:0]       funct = '0;
  logic [31:0]      shamt_ext = '0;
  logic [WIDTH-1:0] operand = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [1:0]       state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_shift_unit #(
    .WIDTH  (WIDTH),
    .SHAMT_W(5),
    .STEP   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct    (funct),
    .shamt_ext(shamt_ext),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one op, scramble the inputs right after acceptance, then follow
  // it to completion and one cycle beyond.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] sh,
                        input logic [31:0] op, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_err);
    int k;
    bit seen;
    logic [31:0] exp_val;
    @(negedge clk);
    start = 1'b1;
    funct = f;
    shamt_ext = sh;
    operand = op;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b0;
    operand = ~op;
    shamt_ext = $urandom_range(0, 31);
    funct = F_SRA;
    k = 1;
    seen = 1'b0;
    while (!seen && k <= MAX_CYCLES) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, " busy_in_shift"}, 32'(busy), 32'd1);
        @(negedge clk);
        k++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    exp_val = exp_q.pop_front();
    if (seen) begin
      check({tag, " latency"}, 32'(k), 32'(exp_lat));
      check({tag, " busy_at_done"}, 32'(busy), 32'd1);
      check({tag, " result"}, result, exp_val);
      check({tag, " err"}, 32'(err), 32'(exp_err));
      @(negedge clk);
      check({tag, " done_pulse_end"}, 32'(done), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check({tag, " err_after"}, 32'(err), 32'd0);
      check({tag, " result_held"}, result, exp_val);
    end
  endtask

  // Start held high with different inputs while busy must be ignored.
  task automatic run_ignore_start();
    int k;
    int dones;
    @(negedge clk);
    start = 1'b1;
    funct = F_SLL;
    shamt_ext = 32'd8;
    operand = 32'h0000_0003;
    exp_q.push_back(32'h0000_0300);
    @(negedge clk);
    operand = 32'hFFFF_FFFF;
    funct = F_SRL;
    shamt_ext = 32'd1;
    k = 1;
    dones = 0;
    while (dones == 0 && k <= MAX_CYCLES) begin
      if (done) begin
        dones++;
        check("ign latency", 32'(k), 32'd3);
        check("ign result", result, exp_q.pop_front());
        start = 1'b0;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ign done_count", 32'(dones), 32'd1);
    check("ign busy_after", 32'(busy), 32'd0);
    check("ign result_held", result, 32'h0000_0300);
  endtask

  // Reset in cycle N+4 of a 31-bit sll: outputs clear at once, no done.
  task automatic run_reset_abort();
    int dones;
    @(negedge clk);
    start = 1'b1;
    funct = F_SLL;
    shamt_ext = 32'd31;
    operand = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst result", result, 32'h0);
    check("rst state", 32'(state_dbg), 32'd0);
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst no_done", 32'(dones), 32'd0);
    check("rst state_idle", 32'(state_dbg), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset result", result, 32'h0);
    check("reset state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sll31", F_SLL, 32'h0000_001F, 32'h0000_0001, 9, 32'h8000_0000, 1'b0);
    run_op("sra5", F_SRA, 32'h0000_0005, 32'h8000_0000, 3, 32'hFC00_0000, 1'b0);
    run_op("srl5", F_SRL, 32'h0000_0005, 32'h8000_0000, 3, 32'h0400_0000, 1'b0);
    run_op("masked0", F_SLL, 32'hFFFF_FFE0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0);
    run_op("badfunct", F_BAD, 32'h0000_0004, 32'hDEAD_BEEF, 1, 32'h0000_0000, 1'b1);
    run_op("sra13", F_SRA, 32'h0000_000D, 32'h8765_4321, 5, 32'hFFFC_3B2A, 1'b0);
    run_op("srl13", F_SRL, 32'h0000_000D, 32'h8765_4321, 5, 32'h0004_3B2A, 1'b0);
    run_op("sll4", F_SLL, 32'h0000_0004, 32'h8765_4321, 2, 32'h7654_3210, 1'b0);
    run_op("sra_pos31", F_SRA, 32'h0000_001F, 32'h7000_0000, 9, 32'h0000_0000, 1'b0);

    run_ignore_start();
    run_reset_abort();
    run_op("after_rst", F_SLL, 32'h0000_001F, 32'h0000_0001, 9, 32'h8000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
